// File: rtl/peri_bus_arbiter.sv
// peri_bus_arbiter: round-robin arbiter that shares one in-order req/gnt/rvalid
// peripheral bus among NUM_HOSTS hosts. Each accepted transaction pushes the
// issuing host into an ID FIFO so that responses are routed back to it.
module peri_bus_arbiter #(
    parameter int unsigned NUM_HOSTS       = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_HOSTS-1:0]        host_req_i,
    input  logic [NUM_HOSTS*AW-1:0]     host_addr_i,
    input  logic [NUM_HOSTS-1:0]        host_write_i,
    input  logic [NUM_HOSTS*DW/8-1:0]   host_be_i,
    input  logic [NUM_HOSTS*DW-1:0]     host_wdata_i,
    output logic [NUM_HOSTS-1:0]        host_gnt_o,
    output logic [NUM_HOSTS-1:0]        host_rvalid_o,
    output logic [DW-1:0]               host_rdata_o,
    output logic                        peri_req_o,
    output logic [AW-1:0]               peri_addr_o,
    output logic                        peri_write_o,
    output logic [DW/8-1:0]             peri_be_o,
    output logic [DW-1:0]               peri_wdata_o,
    input  logic                        peri_gnt_i,
    input  logic                        peri_rvalid_i,
    input  logic [DW-1:0]               peri_rdata_i,
    output logic                        resp_err_o
);
    localparam int unsigned HW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned BW = DW / 8;

    logic [HW-1:0] r_rr;
    logic          r_lock;
    logic [HW-1:0] r_lock_host;
    logic [HW-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [HW-1:0] w_sel;
    logic [HW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_req;
    logic          w_grant;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [HW-1:0] host_inc(input logic [HW-1:0] h);
        return (h == HW'(NUM_HOSTS - 1)) ? '0 : h + 1'b1;
    endfunction

    // Host selection: locked host if mid-handshake, else first requester from rr pointer.
    // Offsets are scanned from highest to lowest so the closest requester wins last.
    always_comb begin
        int unsigned idx;
        w_sel = '0;
        idx   = 0;
        if (r_lock) begin
            w_sel = r_lock_host;
        end else begin
            for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
                idx = int'(r_rr) + (NUM_HOSTS - 1 - k);
                if (idx >= NUM_HOSTS) idx = idx - NUM_HOSTS;
                if (host_req_i[idx]) w_sel = HW'(idx);
            end
        end
    end

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];
    assign w_req   = rst_n & host_req_i[w_sel] & ~w_full;
    assign w_grant = w_req & peri_gnt_i;
    assign w_pop   = rst_n & peri_rvalid_i & ~w_empty;

    assign peri_req_o   = w_req;
    assign peri_addr_o  = host_addr_i[w_sel*AW +: AW];
    assign peri_write_o = host_write_i[w_sel];
    assign peri_be_o    = host_be_i[w_sel*BW +: BW];
    assign peri_wdata_o = host_wdata_i[w_sel*DW +: DW];
    assign host_rdata_o = peri_rdata_i;
    assign resp_err_o   = rst_n & peri_rvalid_i & w_empty;

    // One-hot grant to the selected host and response valid to the FIFO head host.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
            host_gnt_o[i]    = w_grant && (w_sel == HW'(i));
            host_rvalid_o[i] = w_pop && (w_head == HW'(i));
        end
    end

    // Round-robin pointer and handshake lock; lock drops on grant or when the held host withdraws.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_lock      <= 1'b0;
            r_lock_host <= '0;
        end else begin
            r_lock      <= w_req & ~peri_gnt_i;
            r_lock_host <= w_sel;
            if (w_grant) r_rr <= host_inc(w_sel);
        end
    end

    // Issued-host ID FIFO: push on grant, pop on response; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
        end else begin
            if (w_grant) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_grant && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_grant && w_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule
